// File: rtl/imem_loader_pkg.sv
// Shared constants and the loader state encoding for the single-cycle CPU
// instruction memory.
package imem_loader_pkg;

  localparam int IMEM_DEPTH = 64;
  localparam int INSTR_W    = 32;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_HI = 3'd1,
    ST_LEN_LO = 3'd2,
    ST_DATA   = 3'd3,
    ST_CLEAR  = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERR    = 3'd6
  } state_e;

endpackage

// File: rtl/imem_loader_if.sv
// Bus bundle between the loader and its environment: the control inputs,
// the byte stream, the instruction memory write port and the status flags.
//
// Handshake: a byte moves on a rising clk edge where byte_valid and
// byte_ready are both high. The source holds byte_data stable while
// byte_valid is high and no transfer has happened yet. byte_ready depends
// only on loader state, never on byte_valid.
interface imem_loader_if #(
  parameter int ADDR_W = 6
);
  logic              start;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_hold;
  logic              done;
  logic              error;

  // Stream source / system side.
  modport master (
    output start, byte_valid, byte_data,
    input  byte_ready, imem_we, imem_addr, imem_wdata, cpu_hold, done, error
  );

  // Loader side.
  modport slave (
    input  start, byte_valid, byte_data,
    output byte_ready, imem_we, imem_addr, imem_wdata, cpu_hold, done, error
  );
endinterface

// File: rtl/imem_loader_byte_word_packer.sv
// Packs a big-endian byte stream into 32-bit words. word_valid_o pulses
// combinationally on the transfer that carries the fourth (LSB) byte, with
// the complete word on word_o in that same cycle.
module byte_word_packer
  import imem_loader_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clear_i,
  input  logic               byte_valid_i,
  input  logic [7:0]         byte_i,
  output logic [INSTR_W-1:0] word_o,
  output logic               word_valid_o
);

  // Only the three earlier bytes need storage; the fourth is taken
  // straight from the input when the word completes.
  logic [1:0]  idx_q;
  logic [23:0] shift_q;

  assign word_o       = {shift_q, byte_i};
  assign word_valid_o = byte_valid_i && (idx_q == 2'd3);

  // Byte index and shift register; cleared whenever no word is being built.
  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      idx_q   <= 2'd0;
      shift_q <= 24'd0;
    end else if (byte_valid_i) begin
      idx_q   <= idx_q + 2'd1;
      shift_q <= {shift_q[15:0], byte_i};
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Program loader: reads a length-prefixed byte image, writes it into the
// instruction memory, zero-fills the rest and releases the CPU when done.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH  = IMEM_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  imem_loader_if.slave         bus,
  output state_e               dbg_state_o
);

  state_e              state_q, state_d;
  logic [15:0]         count_q, count_d;
  // One bit wider than the address so N == DEPTH compares without wrap.
  logic [ADDR_W:0]     word_idx_q, word_idx_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [INSTR_W-1:0]  wdata_q, wdata_d;

  logic                byte_ready;
  logic                xfer;
  logic [15:0]         len_full;
  logic [INSTR_W-1:0]  pk_word;
  logic                pk_word_valid;

  assign byte_ready = (state_q == ST_LEN_HI) || (state_q == ST_LEN_LO) ||
                      (state_q == ST_DATA);
  assign xfer       = bus.byte_valid && byte_ready;
  assign len_full   = {count_q[15:8], bus.byte_data};

  byte_word_packer u_packer (
    .clk          (clk),
    .rst          (rst),
    .clear_i      (state_q != ST_DATA),
    .byte_valid_i (xfer && (state_q == ST_DATA)),
    .byte_i       (bus.byte_data),
    .word_o       (pk_word),
    .word_valid_o (pk_word_valid)
  );

  // State and write-port registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      count_q    <= 16'd0;
      word_idx_q <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      word_idx_q <= word_idx_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
    end
  end

  // Next-state, length capture, word addressing and zero-fill sequencing.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    word_idx_d = word_idx_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (bus.start) state_d = ST_LEN_HI;
      end

      ST_LEN_HI: begin
        if (xfer) begin
          count_d = {bus.byte_data, count_q[7:0]};
          state_d = ST_LEN_LO;
        end
      end

      ST_LEN_LO: begin
        if (xfer) begin
          count_d    = len_full;
          word_idx_d = '0;
          if ((len_full == 16'd0) || (32'(len_full) > DEPTH)) state_d = ST_ERR;
          else                                                 state_d = ST_DATA;
        end
      end

      ST_DATA: begin
        if (we_q) begin
          // The write for word word_idx_q is on the bus this cycle.
          word_idx_d = word_idx_q + 1'b1;
          if (32'(word_idx_q) + 1 == 32'(count_q)) begin
            if (32'(count_q) < DEPTH) begin
              // Chain straight into the first zero-fill write.
              state_d = ST_CLEAR;
              we_d    = 1'b1;
              addr_d  = ADDR_W'(count_q);
              wdata_d = '0;
            end else begin
              state_d = ST_DONE;
            end
          end
        end else if (pk_word_valid) begin
          we_d    = 1'b1;
          addr_d  = word_idx_q[ADDR_W-1:0];
          wdata_d = pk_word;
        end
      end

      ST_CLEAR: begin
        if (addr_q == ADDR_W'(DEPTH - 1)) begin
          state_d = ST_DONE;
        end else begin
          we_d    = 1'b1;
          addr_d  = addr_q + 1'b1;
          wdata_d = '0;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.byte_ready = byte_ready;
  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign bus.cpu_hold   = (state_q != ST_DONE);
  assign bus.done       = (state_q == ST_DONE);
  assign bus.error      = (state_q == ST_ERR);
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: padded load, full image, bad headers,
// back-pressure, reset mid-load and ignored start pulses.
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam int DEPTH = 64;

  logic   clk;
  logic   rst;
  state_e dbg_state;

  imem_loader_if #(.ADDR_W(6)) bus ();

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(6)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- write monitor (memory model) ----------------
  logic [31:0] mem_m  [DEPTH];
  int          wr_cnt [DEPTH];
  int          total_wr;
  logic [31:0] exp_w  [DEPTH];

  always @(posedge clk) begin
    if (bus.imem_we) begin
      mem_m[bus.imem_addr]  = bus.imem_wdata;
      wr_cnt[bus.imem_addr] = wr_cnt[bus.imem_addr] + 1;
      total_wr              = total_wr + 1;
    end
  end

  // ---------------- scoreboard counters ----------------
  int n_assert;
  int n_fail;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    for (int i = 0; i < DEPTH; i++) begin
      mem_m[i]  = 32'hDEAD_BEEF;
      wr_cnt[i] = 0;
      exp_w[i]  = 32'h0;
    end
    total_wr = 0;
  endtask

  // ---------------- drivers ----------------
  task automatic pulse_start();
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  // Presents one byte after an optional idle gap; returns just after the
  // edge on which it transferred.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int bound;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    bound = 0;
    while (!bus.byte_ready && bound < 50) begin
      @(negedge clk);
      bound++;
    end
    chk("byte_ready_wait", 32'(bus.byte_ready), 32'd1);
    @(posedge clk);
    #1 bus.byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int max_gap);
    for (int k = 3; k >= 0; k--) begin
      send_byte(w[k*8 +: 8], (max_gap > 0) ? int'($urandom_range(1, max_gap)) : 0);
    end
  endtask

  task automatic wait_done(input string tag);
    int bound;
    bound = 0;
    while (!bus.done && bound < 300) begin
      @(negedge clk);
      bound++;
    end
    chk(tag, 32'(bus.done), 32'd1);
  endtask

  // Every location written exactly once with its expected word (or zero).
  task automatic check_image(input int n, input string tag);
    int bad;
    logic [31:0] expv;
    bad = 0;
    for (int i = 0; i < DEPTH; i++) begin
      expv = (i < n) ? exp_w[i] : 32'h0;
      if (mem_m[i] !== expv || wr_cnt[i] != 1) bad++;
    end
    chk({tag, "_bad_locations"}, 32'(bad), 32'd0);
    chk({tag, "_total_writes"}, 32'(total_wr), 32'(DEPTH));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_byte_ready"}, 32'(bus.byte_ready), 32'd0);
    chk({tag, "_imem_we"},    32'(bus.imem_we),    32'd0);
    chk({tag, "_imem_addr"},  32'(bus.imem_addr),  32'd0);
    chk({tag, "_imem_wdata"}, bus.imem_wdata,      32'd0);
    chk({tag, "_cpu_hold"},   32'(bus.cpu_hold),   32'd1);
    chk({tag, "_done"},       32'(bus.done),       32'd0);
    chk({tag, "_error"},      32'(bus.error),      32'd0);
    chk({tag, "_state"},      32'(dbg_state),      32'(ST_IDLE));
  endtask

  function automatic logic [31:0] img_word(input int i);
    return {8'(i), 8'(255 - i), 8'(i * 3), 8'hA5};
  endfunction

  // ---------------- directed sequence ----------------
  initial begin
    int bad;
    n_assert = 0;
    n_fail   = 0;
    rst            = 1'b1;
    bus.start      = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    clear_log();

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // ---- N=2 with zero fill ----
    clear_log();
    exp_w[0] = 32'h2010_0015;
    exp_w[1] = 32'h2011_0017;
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_word(32'h2010_0015, 0);
    @(negedge clk);
    chk("n2_w0_we",   32'(bus.imem_we),   32'd1);
    chk("n2_w0_addr", 32'(bus.imem_addr), 32'd0);
    chk("n2_w0_data", bus.imem_wdata,     32'h2010_0015);
    chk("n2_w0_ready", 32'(bus.byte_ready), 32'd1);
    send_word(32'h2011_0017, 0);
    @(negedge clk);
    chk("n2_w1_we",   32'(bus.imem_we),   32'd1);
    chk("n2_w1_addr", 32'(bus.imem_addr), 32'd1);
    chk("n2_w1_data", bus.imem_wdata,     32'h2011_0017);
    @(negedge clk);
    chk("n2_clr_first_we",   32'(bus.imem_we),   32'd1);
    chk("n2_clr_first_addr", 32'(bus.imem_addr), 32'd2);
    chk("n2_clr_first_data", bus.imem_wdata,     32'd0);
    chk("n2_clr_state",      32'(dbg_state),     32'(ST_CLEAR));
    bad = 0;
    for (int a = 3; a < DEPTH; a++) begin
      @(negedge clk);
      if (bus.imem_we !== 1'b1 || 32'(bus.imem_addr) != a || bus.imem_wdata !== 32'd0) bad++;
    end
    chk("n2_clr_run_bad_cycles", 32'(bad), 32'd0);
    @(negedge clk);
    chk("n2_done",     32'(bus.done),     32'd1);
    chk("n2_cpu_hold", 32'(bus.cpu_hold), 32'd0);
    chk("n2_we_after", 32'(bus.imem_we),  32'd0);
    check_image(2, "n2");

    // ---- start in DONE, then N=64 full image ----
    clear_log();
    for (int i = 0; i < DEPTH; i++) exp_w[i] = img_word(i);
    pulse_start();
    @(negedge clk);
    chk("restart_cpu_hold", 32'(bus.cpu_hold), 32'd1);
    chk("restart_done",     32'(bus.done),     32'd0);
    send_byte(8'h00, 0);
    send_byte(8'h40, 0);
    for (int i = 0; i < DEPTH; i++) send_word(img_word(i), 0);
    @(negedge clk);
    chk("n64_last_we",   32'(bus.imem_we),   32'd1);
    chk("n64_last_addr", 32'(bus.imem_addr), 32'd63);
    chk("n64_last_data", bus.imem_wdata,     img_word(63));
    chk("n64_done_early", 32'(bus.done),     32'd0);
    @(negedge clk);
    chk("n64_done",  32'(bus.done),    32'd1);
    chk("n64_we_off", 32'(bus.imem_we), 32'd0);
    check_image(64, "n64");

    // ---- bad headers ----
    clear_log();
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    @(negedge clk);
    chk("n0_error",      32'(bus.error),      32'd1);
    chk("n0_cpu_hold",   32'(bus.cpu_hold),   32'd1);
    chk("n0_byte_ready", 32'(bus.byte_ready), 32'd0);
    pulse_start();
    @(negedge clk);
    chk("n0_error_clear", 32'(bus.error), 32'd0);
    send_byte(8'h00, 0);
    send_byte(8'h41, 0);
    @(negedge clk);
    chk("n65_error",    32'(bus.error),    32'd1);
    chk("n65_cpu_hold", 32'(bus.cpu_hold), 32'd1);
    chk("err_no_writes", 32'(total_wr),    32'd0);
    pulse_start();
    @(negedge clk);
    chk("n65_error_clear", 32'(bus.error), 32'd0);
    chk("n65_state",       32'(dbg_state), 32'(ST_LEN_HI));

    // ---- back-pressure N=3, start pulses in DATA and CLEAR ----
    clear_log();
    exp_w[0] = 32'h8C22_0004;
    exp_w[1] = 32'h0043_2820;
    exp_w[2] = 32'hAC05_0008;
    send_byte(8'h00, int'($urandom_range(1, 5)));
    send_byte(8'h03, int'($urandom_range(1, 5)));
    send_byte(8'h8C, int'($urandom_range(1, 5)));
    send_byte(8'h22, int'($urandom_range(1, 5)));
    pulse_start();
    @(negedge clk);
    chk("start_in_data_state", 32'(dbg_state), 32'(ST_DATA));
    send_byte(8'h00, int'($urandom_range(1, 5)));
    send_byte(8'h04, int'($urandom_range(1, 5)));
    send_word(32'h0043_2820, 5);
    send_word(32'hAC05_0008, 5);
    repeat (5) @(negedge clk);
    pulse_start();
    @(negedge clk);
    chk("start_in_clear_state", 32'(dbg_state), 32'(ST_CLEAR));
    wait_done("bp_done_wait");
    check_image(3, "bp");

    // ---- reset after 6 data bytes, then a clean reload ----
    clear_log();
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_word(32'h1122_3344, 0);
    send_byte(8'h55, 0);
    send_byte(8'h66, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrst");
    rst = 1'b0;
    clear_log();
    exp_w[0] = 32'h0102_0304;
    exp_w[1] = 32'hA0B0_C0D0;
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_word(32'h0102_0304, 0);
    send_word(32'hA0B0_C0D0, 0);
    wait_done("reload_done_wait");
    chk("reload_cpu_hold", 32'(bus.cpu_hold), 32'd0);
    check_image(2, "reload");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
